jk_bank_scheduler: RTL and testbench

JK_BANK_SCHEDULER -- requirements
Module: jk_bank_scheduler

---
 rtl/jk_ctrl_pkg.sv | 33 +++
 rtl/jk_flip_flop_master_slave.sv | 24 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/jk_bank_scheduler.sv | 146 ++++++++++++++
 tb/tb_jk_bank_scheduler.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/jk_ctrl_pkg.sv
// Shared encodings and defaults for the JK bank scheduler.
package jk_ctrl_pkg;

    localparam int DEF_N_REQ     = 3;
    localparam int DEF_WIDTH     = 4;
    localparam int DEF_MAX_RETRY = 2;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_SET  = 2'b01,
        OP_RST  = 2'b10,
        OP_TGL  = 2'b11
    } jk_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_CHECK = 2'b10
    } jk_state_e;

    // Per-bit {J,K} pattern for an op; applied only to masked bits.
    function automatic logic [1:0] jk_drive(input jk_op_e op_in);
        logic [1:0] jk;
        case (op_in)
            OP_SET:  jk = 2'b10;
            OP_RST:  jk = 2'b01;
            OP_TGL:  jk = 2'b11;
            default: jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_flip_flop_master_slave.sv
// One JK storage element of the external bank (edge-triggered master-slave behaviour).
module jk_flip_flop_master_slave (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic j_i,
    input  logic k_i,
    output logic q_o
);

    // Hold / reset / set / toggle on the rising edge; async clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= 1'b0;
        end else begin
            case ({j_i, k_i})
                2'b01:   q_o <= 1'b0;
                2'b10:   q_o <= 1'b1;
                2'b11:   q_o <= ~q_o;
                default: q_o <= q_o;
            endcase
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or above ptr, else lowest below it.
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o
);

    logic found;

    // Two ordered scans give the wrap-around priority starting at ptr.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_i[i] && (i >= int'(ptr_i))) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_i[i] && (i < int'(ptr_i))) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jk_bank_scheduler.sv
// Arbitrates requesters onto a shared JK bank, drives J/K for one cycle,
// then verifies the bank feedback and retries failed set/reset ops.
module jk_bank_scheduler
    import jk_ctrl_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_RETRY = DEF_MAX_RETRY
) (
    input  logic                   C,
    input  logic                   RESETn,
    input  logic [N_REQ-1:0]       req,
    input  logic [2*N_REQ-1:0]     op,
    input  logic [WIDTH*N_REQ-1:0] mask,
    input  logic [WIDTH-1:0]       Q,
    output logic [WIDTH-1:0]       J,
    output logic [WIDTH-1:0]       K,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   err
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    jk_state_e         state_q;
    logic [PW-1:0]     ptr_q, win_idx_q, win_idx, ptr_next;
    logic [N_REQ-1:0]  gnt_q, win;
    jk_op_e            op_q, op_sel;
    logic [WIDTH-1:0]  mask_q, mask_sel, expect_q, expect_sel;
    logic [WIDTH-1:0]  j_q, k_q, j_sel, k_sel, j_retry, k_retry;
    logic [RW-1:0]     retry_q;
    logic [1:0]        drv_sel, drv_retry;
    logic              match, can_retry, finish;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PW)
    ) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (win)
    );

    // Pull the winner's index, op and mask out of the flat request buses.
    always_comb begin
        win_idx  = '0;
        op_sel   = OP_HOLD;
        mask_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) begin
                win_idx  = PW'(i);
                op_sel   = jk_op_e'(op[2*i +: 2]);
                mask_sel = mask[WIDTH*i +: WIDTH];
            end
        end
    end

    // Expected bank value and J/K patterns for a new grant and for a retry.
    always_comb begin
        expect_sel = Q;
        case (op_sel)
            OP_SET:  expect_sel = Q | mask_sel;
            OP_RST:  expect_sel = Q & ~mask_sel;
            OP_TGL:  expect_sel = Q ^ mask_sel;
            default: expect_sel = Q;
        endcase
        drv_sel   = jk_drive(op_sel);
        j_sel     = {WIDTH{drv_sel[1]}} & mask_sel;
        k_sel     = {WIDTH{drv_sel[0]}} & mask_sel;
        drv_retry = jk_drive(op_q);
        j_retry   = {WIDTH{drv_retry[1]}} & mask_q;
        k_retry   = {WIDTH{drv_retry[0]}} & mask_q;
    end

    assign match     = ((Q ^ expect_q) & mask_q) == '0;
    // Toggle is never retried: a second toggle would undo the first.
    assign can_retry = ((op_q == OP_SET) || (op_q == OP_RST)) && (retry_q < RW'(MAX_RETRY));
    assign finish    = (state_q == ST_CHECK) && (match || !can_retry);
    assign ptr_next  = (win_idx_q == PW'(N_REQ - 1)) ? '0 : win_idx_q + PW'(1);

    assign J    = j_q;
    assign K    = k_q;
    // The grant is visible in the arbitration cycle itself, then held registered.
    assign gnt  = ((state_q == ST_IDLE) && RESETn) ? win : gnt_q;
    assign done = finish ? gnt_q : '0;
    assign err  = finish && !match;

    // Transaction FSM: IDLE arbitrates, DRIVE pulses J/K, CHECK verifies or retries.
    always_ff @(posedge C or negedge RESETn) begin
        if (!RESETn) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            win_idx_q <= '0;
            gnt_q     <= '0;
            op_q      <= OP_HOLD;
            mask_q    <= '0;
            expect_q  <= '0;
            retry_q   <= '0;
            j_q       <= '0;
            k_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    j_q <= '0;
                    k_q <= '0;
                    if (req != '0) begin
                        gnt_q     <= win;
                        win_idx_q <= win_idx;
                        op_q      <= op_sel;
                        mask_q    <= mask_sel;
                        expect_q  <= expect_sel;
                        retry_q   <= '0;
                        j_q       <= j_sel;
                        k_q       <= k_sel;
                        state_q   <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    j_q     <= '0;
                    k_q     <= '0;
                    state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (match || !can_retry) begin
                        gnt_q   <= '0;
                        ptr_q   <= ptr_next;
                        state_q <= ST_IDLE;
                    end else begin
                        retry_q <= retry_q + RW'(1);
                        j_q     <= j_retry;
                        k_q     <= k_retry;
                        state_q <= ST_DRIVE;
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    j_q     <= '0;
                    k_q     <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_bank_scheduler.sv
// Directed bench for jk_bank_scheduler driving a real bank of JK flip-flops.
module tb_jk_bank_scheduler;

    localparam int N   = 3;
    localparam int W   = 4;
    localparam int MR  = 2;
    localparam int SBW = N + 1;

    logic           C = 1'b0;
    logic           RESETn = 1'b0;
    logic [N-1:0]   req_v;
    logic [2*N-1:0] op_v;
    logic [W*N-1:0] mask_v;
    logic [W-1:0]   ff_q, q_fb, stuck, J, K;
    logic [N-1:0]   gnt, done;
    logic           err;

    int             n_asserts = 0;
    int             n_fail = 0;
    logic [SBW-1:0] exp_q[$];
    logic [SBW-1:0] sb_e;

    always #5 C = ~C;

    // Stuck bits force the feedback low regardless of the flip-flop contents.
    assign q_fb = ff_q & ~stuck;

    jk_bank_scheduler #(.N_REQ(N), .WIDTH(W), .MAX_RETRY(MR)) dut (
        .C      (C),
        .RESETn (RESETn),
        .req    (req_v),
        .op     (op_v),
        .mask   (mask_v),
        .Q      (q_fb),
        .J      (J),
        .K      (K),
        .gnt    (gnt),
        .done   (done),
        .err    (err)
    );

    for (genvar g = 0; g < W; g++) begin : g_ff
        jk_flip_flop_master_slave u_ff (
            .clk_i (C),
            .rst_ni(RESETn),
            .j_i   (J[g]),
            .k_i   (K[g]),
            .q_o   (ff_q[g])
        );
    end

    task automatic tick;
        @(posedge C);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_inputs;
        req_v  = '0;
        op_v   = '0;
        mask_v = '0;
    endtask

    task automatic drive(input int r, input logic [1:0] o, input logic [W-1:0] m);
        req_v[r]         = 1'b1;
        op_v[2*r +: 2]   = o;
        mask_v[W*r +: W] = m;
    endtask

    function automatic logic [W-1:0] j_model(input logic [1:0] o, input logic [W-1:0] m);
        return (o == 2'b01 || o == 2'b11) ? m : '0;
    endfunction

    function automatic logic [W-1:0] k_model(input logic [1:0] o, input logic [W-1:0] m);
        return (o == 2'b10 || o == 2'b11) ? m : '0;
    endfunction

    // A single transaction expected to succeed on the first attempt.
    task automatic do_txn(input string tag, input int r, input logic [1:0] o,
                          input logic [W-1:0] m, input logic [W-1:0] q_after);
        logic [N-1:0] who;
        who    = '0;
        who[r] = 1'b1;
        clear_inputs();
        drive(r, o, m);
        exp_q.push_back({who, 1'b0});
        #1;
        check({tag, "_gnt_idle"}, gnt, who);
        tick();
        check({tag, "_gnt_drive"}, gnt, who);
        check({tag, "_j_drive"}, J, j_model(o, m));
        check({tag, "_k_drive"}, K, k_model(o, m));
        check({tag, "_done_drive"}, done, 0);
        clear_inputs();
        tick();
        check({tag, "_gnt_check"}, gnt, who);
        check({tag, "_jk_check"}, {J, K}, 0);
        check({tag, "_q"}, q_fb, q_after);
        check({tag, "_done"}, done, who);
        check({tag, "_err"}, err, 0);
        tick();
        check({tag, "_gnt_after"}, gnt, 0);
        check({tag, "_done_after"}, done, 0);
    endtask

    // A transaction expected to end with err after exp_drives DRIVE cycles.
    task automatic run_fail(input string tag, input int r, input logic [1:0] o,
                            input logic [W-1:0] m, input int exp_drives);
        logic [N-1:0] who;
        int drives;
        int cycles;
        bit seen;
        who    = '0;
        who[r] = 1'b1;
        drives = 0;
        cycles = 0;
        seen   = 1'b0;
        clear_inputs();
        drive(r, o, m);
        exp_q.push_back({who, 1'b1});
        #1;
        check({tag, "_gnt_idle"}, gnt, who);
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            cycles++;
            if (J != '0) drives++;
            if (done != '0) begin
                seen = 1'b1;
                check({tag, "_done"}, done, who);
                check({tag, "_err"}, err, 1);
            end
        end
        check({tag, "_completed"}, seen, 1);
        check({tag, "_drives"}, drives, exp_drives);
        check({tag, "_cycles"}, cycles, 2 * exp_drives);
        clear_inputs();
        tick();
        check({tag, "_gnt_after"}, gnt, 0);
    endtask

    // Scoreboard: every completion pops one expected {done, err}; gnt must stay one-hot or zero.
    always @(negedge C) begin
        if (RESETn) begin
            n_asserts++;
            assert ($onehot0(gnt)) else begin
                n_fail++;
                $error("FAIL gnt_onehot0: observed %b expected zero or one-hot", gnt);
            end
            if (done != '0 || err) begin
                n_asserts++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $error("FAIL sb_unexpected: observed done=%b err=%b expected no completion", done, err);
                end else begin
                    sb_e = exp_q.pop_front();
                    assert ({done, err} === sb_e) else begin
                        n_fail++;
                        $error("FAIL sb_completion: observed %b expected %b", {done, err}, sb_e);
                    end
                end
            end
        end
    end

    initial begin
        logic [N-1:0] order [4];
        logic [W-1:0] cmask [4];
        order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
        cmask[0] = 4'b0001; cmask[1] = 4'b0010; cmask[2] = 4'b0100; cmask[3] = 4'b0001;

        // Power-on reset
        clear_inputs();
        stuck  = '0;
        RESETn = 1'b0;
        repeat (2) tick();
        check("rst_j", J, 0);
        check("rst_k", K, 0);
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_q", q_fb, 0);
        RESETn = 1'b1;

        // Single transactions: set, hold, empty mask, reset, set, toggle
        do_txn("set0", 0, 2'b01, 4'b0101, 4'b0101);
        do_txn("hold2", 2, 2'b00, 4'b1010, 4'b0101);
        do_txn("mask0", 1, 2'b01, 4'b0000, 4'b0101);
        do_txn("rst0", 0, 2'b10, 4'b1111, 4'b0000);
        do_txn("set0b", 0, 2'b01, 4'b0011, 4'b0011);
        do_txn("tgl1", 1, 2'b11, 4'b1111, 4'b1100);

        // Contention with all requesters held from reset
        RESETn = 1'b0;
        clear_inputs();
        drive(0, 2'b01, 4'b0001);
        drive(1, 2'b01, 4'b0010);
        drive(2, 2'b01, 4'b0100);
        #1;
        check("crst_gnt", gnt, 0);
        check("crst_q", q_fb, 0);
        tick();
        RESETn = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back({order[i], 1'b0});
        #1;
        for (int k = 0; k < 12; k++) begin
            check("cont_gnt", gnt, order[k / 3]);
            check("cont_j", J, (k % 3 == 1) ? cmask[k / 3] : 4'b0000);
            check("cont_done", done, (k % 3 == 2) ? order[k / 3] : 3'b000);
            if (k == 11) clear_inputs();
            tick();
        end
        check("cont_gnt_end", gnt, 0);
        check("cont_q", q_fb, 4'b0111);

        // Feedback bit 0 stuck low: set retries, toggle fails at once
        stuck = 4'b0001;
        run_fail("setfail", 1, 2'b01, 4'b0001, 1 + MR);
        run_fail("tglfail", 1, 2'b11, 4'b0001, 1);
        stuck = '0;
        check("fail_q", q_fb, 4'b0110);

        // Reset during DRIVE of requester 2 (pointer is at 2 at this point)
        clear_inputs();
        drive(2, 2'b01, 4'b1000);
        #1;
        check("abort_gnt_idle", gnt, 3'b100);
        tick();
        check("abort_j_drive", J, 4'b1000);
        #1;
        RESETn = 1'b0;
        clear_inputs();
        drive(0, 2'b00, 4'b0000);
        drive(2, 2'b00, 4'b0000);
        #1;
        check("abort_j", J, 0);
        check("abort_k", K, 0);
        check("abort_gnt", gnt, 0);
        check("abort_done", done, 0);
        check("abort_err", err, 0);
        tick();
        RESETn = 1'b1;
        exp_q.push_back({3'b001, 1'b0});
        #1;
        check("post_gnt_first", gnt, 3'b001);
        tick();
        tick();
        check("post_done0", done, 3'b001);
        exp_q.push_back({3'b100, 1'b0});
        tick();
        check("post_gnt_second", gnt, 3'b100);
        tick();
        clear_inputs();
        tick();
        check("post_done2", done, 3'b100);
        tick();
        check("post_gnt_end", gnt, 0);

        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
